alu_pipe: RTL



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_core.sv | 106 ++++++++++
 rtl/alu_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-stage integer ALU pipeline: op bit
// positions, op vector width and the payload captured by stage 1.
package alu_pkg;

  // Width of the one-hot op vector
  localparam int OP_WIDTH = 11;

  // Widest supported datapath; narrower instances zero-extend into the payload
  localparam int XLEN_MAX = 64;

  // Bit positions inside the one-hot op vector
  localparam int OP_ADD   = 0;
  localparam int OP_SLT   = 1;
  localparam int OP_XOR   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_AND   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SUB   = 8;
  localparam int OP_LUI   = 9;
  localparam int OP_AUIPC = 10;

  // Operands and decode bits held by stage 1 between accept and compute
  typedef struct packed {
    logic [XLEN_MAX-1:0] src1;
    logic [XLEN_MAX-1:0] src2;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] pc;
    logic [OP_WIDTH-1:0] op;
    logic                is_word;
    logic                is_unsigned;
    logic                is_imm;
  } s1_payload_t;

  // True when exactly one op bit is set
  function automatic logic op_is_onehot(input logic [OP_WIDTH-1:0] op);
    return $onehot(op);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath between the stage-1 payload and the stage-2
// result register. Word ops work on the low 32 bits and sign-extend.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  s1_payload_t       pl_i,
  output logic [XLEN-1:0]   result_o,
  output logic              illegal_o
);

  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic [5:0]      shamt_s;
  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] diff_s;
  logic [XLEN-1:0] add_s;
  logic [XLEN-1:0] sub_s;
  logic [XLEN-1:0] slt_s;
  logic [XLEN-1:0] sll_s;
  logic [XLEN-1:0] srl_s;
  logic [XLEN-1:0] sra_s;
  logic [31:0]     a32_s;
  logic            lt_s;

  // Sign-extend a 32-bit word result to the datapath width
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Operand selection: AUIPC uses the PC as a and always takes the immediate
  always_comb begin
    if (pl_i.op[OP_AUIPC]) begin
      a_s = pl_i.pc[XLEN-1:0];
    end else begin
      a_s = pl_i.src1[XLEN-1:0];
    end
    if (pl_i.is_imm || pl_i.op[OP_AUIPC]) begin
      b_s = pl_i.imm[XLEN-1:0];
    end else begin
      b_s = pl_i.src2[XLEN-1:0];
    end
    if (pl_i.is_word || (XLEN == 32)) begin
      shamt_s = {1'b0, b_s[4:0]};
    end else begin
      shamt_s = b_s[5:0];
    end
  end

  // Arithmetic, compare and shift units, with word variants folded in
  always_comb begin
    sum_s  = a_s + b_s;
    diff_s = a_s - b_s;
    a32_s  = a_s[31:0];
    if (pl_i.is_unsigned) begin
      lt_s = (a_s < b_s);
    end else begin
      lt_s = ($signed(a_s) < $signed(b_s));
    end
    slt_s = {{(XLEN-1){1'b0}}, lt_s};
    if (pl_i.is_word) begin
      add_s = sext32(sum_s[31:0]);
      sub_s = sext32(diff_s[31:0]);
      sll_s = sext32(a32_s << shamt_s[4:0]);
      srl_s = sext32(a32_s >> shamt_s[4:0]);
      sra_s = sext32($signed(a32_s) >>> shamt_s[4:0]);
    end else begin
      add_s = sum_s;
      sub_s = diff_s;
      sll_s = a_s << shamt_s;
      srl_s = a_s >> shamt_s;
      sra_s = $signed(a_s) >>> shamt_s;
    end
  end

  // Result select; anything that is not exactly one-hot yields zero and flags illegal
  always_comb begin
    result_o  = {XLEN{1'b0}};
    illegal_o = 1'b0;
    if (!op_is_onehot(pl_i.op)) begin
      illegal_o = 1'b1;
      result_o  = {XLEN{1'b0}};
    end else begin
      illegal_o = 1'b0;
      case (1'b1)
        pl_i.op[OP_ADD]:   result_o = add_s;
        pl_i.op[OP_SLT]:   result_o = slt_s;
        pl_i.op[OP_XOR]:   result_o = a_s ^ b_s;
        pl_i.op[OP_OR]:    result_o = a_s | b_s;
        pl_i.op[OP_AND]:   result_o = a_s & b_s;
        pl_i.op[OP_SLL]:   result_o = sll_s;
        pl_i.op[OP_SRL]:   result_o = srl_s;
        pl_i.op[OP_SRA]:   result_o = sra_s;
        pl_i.op[OP_SUB]:   result_o = sub_s;
        pl_i.op[OP_LUI]:   result_o = pl_i.imm[XLEN-1:0];
        pl_i.op[OP_AUIPC]: result_o = sum_s;
        default:           result_o = {XLEN{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake on both sides.
// S1 holds the accepted op, S2 holds its computed result. flush and
// reset empty both stages; reset also zeroes the visible result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PC_WIDTH  = 48,
  parameter int TAG_WIDTH = 6,
  parameter int OP_WIDTH  = alu_pkg::OP_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_src1,
  input  logic [XLEN-1:0]      in_src2,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic                 in_is_word,
  input  logic                 in_is_unsigned,
  input  logic                 in_is_imm,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal
);

  logic                 s1_valid_q, s1_valid_d;
  s1_payload_t          s1_pl_q,    s1_pl_d;
  logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]      s2_result_q, s2_result_d;
  logic [TAG_WIDTH-1:0] s2_tag_q,   s2_tag_d;
  logic                 s2_illegal_q, s2_illegal_d;

  logic                 s1_adv_s;
  s1_payload_t          in_pl_s;
  logic [XLEN-1:0]      core_result_s;
  logic                 core_illegal_s;

  // S1 may move on when S2 is empty or its result is being taken
  always_comb begin
    s1_adv_s = (!s2_valid_q) || out_ready;
    in_ready = (!s1_valid_q) || s1_adv_s;
  end

  // Pack the incoming op into the stage-1 payload, zero-extending narrow fields
  always_comb begin
    in_pl_s             = {$bits(s1_payload_t){1'b0}};
    in_pl_s.src1        = XLEN_MAX'(in_src1);
    in_pl_s.src2        = XLEN_MAX'(in_src2);
    in_pl_s.imm         = XLEN_MAX'(in_imm);
    in_pl_s.pc          = XLEN_MAX'(in_pc);
    in_pl_s.op          = in_op;
    in_pl_s.is_word     = in_is_word;
    in_pl_s.is_unsigned = in_is_unsigned;
    in_pl_s.is_imm      = in_is_imm;
  end

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .pl_i      (s1_pl_q),
    .result_o  (core_result_s),
    .illegal_o (core_illegal_s)
  );

  // S1 next state: flush empties it (dropping a same-cycle accept), otherwise load on ready
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pl_d    = s1_pl_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_pl_d  = in_pl_s;
        s1_tag_d = in_tag;
      end else begin
        s1_pl_d  = s1_pl_q;
        s1_tag_d = s1_tag_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: take S1's result when advancing; data holds while stalled or empty
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    s2_illegal_d = s2_illegal_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = core_result_s;
        s2_tag_d     = s1_tag_q;
        s2_illegal_d = core_illegal_s;
      end else begin
        s2_result_d  = s2_result_q;
        s2_tag_d     = s2_tag_q;
        s2_illegal_d = s2_illegal_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage registers; reset wins over flush and handshake and clears the visible result
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_pl_q      <= {$bits(s1_payload_t){1'b0}};
      s1_tag_q     <= {TAG_WIDTH{1'b0}};
      s2_valid_q   <= 1'b0;
      s2_result_q  <= {XLEN{1'b0}};
      s2_tag_q     <= {TAG_WIDTH{1'b0}};
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_pl_q      <= s1_pl_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;

endmodule
